blind_cycler: RTL and testbench

Open-loop modulo counter: each rising edge on the `nxt` request input advances a 3-bit position code by one step. `dir` selects whether the step is up or down. There is no feedback or acknowledge from downstream; the block only produces the current position on `out_num`. It sits between a slow step-request source (button, timer tick, sequencer) and logic that decodes the position, for example a mux select or LED index.

---
 rtl/blind_cycler.sv | 76 +++++++
 tb/tb_blind_cycler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/blind_cycler.sv
// blind_cycler: open-loop modulo position counter advanced by rising edges of nxt.
// Define BLIND_CYCLER_SYNC_EN to add two-flop synchronizers on nxt and dir.
module blind_cycler #(
    parameter int CYCLE_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dir,
    input  logic       nxt,
    output logic [2:0] out_num
);
    localparam logic [2:0] LAST = 3'(CYCLE_LEN - 1);

    logic nxt_s;
    logic dir_s;
    logic nxt_h;
    logic hist_vld;
    logic step;

    function automatic logic [2:0] step_up(input logic [2:0] pos);
        return (pos == LAST) ? 3'd0 : pos + 3'd1;
    endfunction

    function automatic logic [2:0] step_dn(input logic [2:0] pos);
        return (pos == 3'd0) ? LAST : pos - 3'd1;
    endfunction

`ifdef BLIND_CYCLER_SYNC_EN
    logic nxt_p0;
    logic dir_p0;
    logic vld_p0;
    logic vld_p1;

    // Stage p0 -> s: two-flop synchronizers, plus a fill marker that keeps the
    // edge history primed until post-reset flush zeros have left the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_p0 <= 1'b0;
            nxt_s  <= 1'b0;
            dir_p0 <= 1'b0;
            dir_s  <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            nxt_p0 <= nxt;
            nxt_s  <= nxt_p0;
            dir_p0 <= dir;
            dir_s  <= dir_p0;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
        end
    end

    assign hist_vld = vld_p1;
`else
    assign nxt_s    = nxt;
    assign dir_s    = dir;
    assign hist_vld = 1'b1;
`endif

    assign step = nxt_s & ~nxt_h;

    // Edge history and position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_h   <= 1'b1;
            out_num <= 3'd0;
        end else begin
            nxt_h <= hist_vld ? nxt_s : 1'b1;
            if (step) begin
                out_num <= dir_s ? step_dn(out_num) : step_up(out_num);
            end
        end
    end

endmodule

// File: tb/tb_blind_cycler.sv
// tb_blind_cycler: randomized and directed stimulus on two blind_cycler instances
// (CYCLE_LEN 8 and 5) checked each cycle against a modular-arithmetic reference model.
module tb_blind_cycler;
`ifdef BLIND_CYCLER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       nxt   = 1'b0;
    logic       dir   = 1'b0;
    logic [2:0] out8;
    logic [2:0] out5;

    int         n_vec = 0;
    int         n_err = 0;
    int         pos8;
    int         pos5;
    logic       prev;
    logic [1:0] q[$];

    blind_cycler #(.CYCLE_LEN(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .dir    (dir),
        .nxt    (nxt),
        .out_num(out8)
    );

    blind_cycler #(.CYCLE_LEN(5)) u_dut5 (
        .clk    (clk),
        .rst_n  (rst_n),
        .dir    (dir),
        .nxt    (nxt),
        .out_num(out5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wrap(input int pos, input int len, input logic down);
        return down ? (pos + len - 1) % len : (pos + 1) % len;
    endfunction

    task automatic model_reset();
        pos8 = 0;
        pos5 = 0;
        prev = 1'b1;
        q.delete();
    endtask

    // Drive one clock worth of inputs, advance the model, check both outputs.
    task automatic cycle(input logic n, input logic d);
        logic [1:0] s;
        nxt = n;
        dir = d;
        @(posedge clk);
        if (rst_n) begin
            q.push_back({n, d});
            if (q.size() > LAT) begin
                s = q.pop_front();
                if (s[1] && !prev) begin
                    pos8 = wrap(pos8, 8, s[0]);
                    pos5 = wrap(pos5, 5, s[0]);
                end
                prev = s[1];
            end
        end
        #1;
        chk("out8", out8, pos8);
        chk("out5", out5, pos5);
    endtask

    // Called at posedge+1: drop reset mid-cycle, check it acts without a clock.
    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst8", out8, 0);
        chk("rst5", out5, 0);
        repeat (hold) cycle(nxt, dir);
        rst_n = 1'b1;
    endtask

    initial begin
        int   len;
        logic lvl;
        logic d;

        model_reset();
        nxt = 1'b1;
        dir = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cycle(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (12) cycle(1'b1, 1'b0);
        chk("nospur8", out8, 0);
        chk("nospur5", out5, 0);

        for (int i = 0; i < 9; i++) begin
            repeat (10) cycle(1'b0, 1'b0);
            repeat (10) cycle(1'b1, 1'b0);
        end
        chk("upwrap8", out8, 1);
        chk("upwrap5", out5, 4);

        async_reset(3);
        for (int i = 0; i < 3; i++) begin
            repeat (10) cycle(1'b0, 1'b1);
            repeat (10) cycle(1'b1, 1'b1);
        end
        chk("down8", out8, 5);
        chk("down5", out5, 2);

        repeat (5) cycle(1'b0, 1'b1);
        repeat (50) cycle(1'b1, 1'b1);
        repeat (50) cycle(1'b0, 1'b1);
        chk("held8", out8, 4);
        chk("held5", out5, 1);

        repeat (10) cycle(1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0);
        chk("coin8", out8, 5);
        chk("coin5", out5, 2);

        cycle(1'b1, 1'b0);
        async_reset(4);
        repeat (6) cycle(1'b1, 1'b0);
        chk("pend8", out8, 0);
        chk("pend5", out5, 0);

        for (int s = 0; s < 150; s++) begin
            len = $urandom_range(2, 8);
            lvl = ~nxt;
            d   = dir;
            if ($urandom_range(0, 2) == 0) d = 1'($urandom_range(0, 1));
            for (int c = 0; c < len; c++) cycle(lvl, d);
            if (s == 90) async_reset(2);
        end
        repeat (5) cycle(1'b0, dir);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
